// File: rtl/i2c_rtc_responder_pkg.sv
// ---------------------------------------------------------------------------
// i2c_rtc_responder_pkg
// Shared definitions for the DS1307-style I2C RTC responder:
//   - FSM state encoding used by the responder top level
//   - DS1307 register indices (seconds .. control)
//   - default 7-bit target address
// ---------------------------------------------------------------------------
package i2c_rtc_responder_pkg;

  localparam logic [6:0] DEFAULT_I2C_ADDR = 7'h68;

  localparam int REG_SEC   = 0;
  localparam int REG_MIN   = 1;
  localparam int REG_HOUR  = 2;
  localparam int REG_DOW   = 3;
  localparam int REG_DATE  = 4;
  localparam int REG_MONTH = 5;
  localparam int REG_YEAR  = 6;
  localparam int REG_CTRL  = 7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WR_PTR,
    ST_WR_DATA,
    ST_WR_ACK,
    ST_RD_BYTE,
    ST_RD_ACK
  } rtcState_t;

endpackage

// File: rtl/i2c_rtc_responder_if.sv
// ---------------------------------------------------------------------------
// i2c_rtc_responder_if
// I2C pad bundle between the bus master (board or bench) and the responder.
//   scl_i   pad-level SCL as seen by the responder
//   sda_i   pad-level SDA as seen by the responder (wired-AND of all drivers)
//   sda_oe  1 = responder pulls SDA low (open-drain), 0 = released
// Modports:
//   slave   the responder: samples scl_i/sda_i, drives sda_oe
//   master  the bus side: drives scl_i/sda_i, observes sda_oe
// ---------------------------------------------------------------------------
interface i2c_rtc_responder_if;

  logic scl_i;
  logic sda_i;
  logic sda_oe;

  modport slave (
    input  scl_i,
    input  sda_i,
    output sda_oe
  );

  modport master (
    output scl_i,
    output sda_i,
    input  sda_oe
  );

endinterface

// File: rtl/i2c_rtc_responder_line_filter.sv
// ---------------------------------------------------------------------------
// i2c_line_filter
// Conditions one asynchronous I2C pad: 2-FF synchroniser, then a stability
// filter that only accepts a new level after it has been held for FILTER_LEN
// consecutive clk cycles, then one-cycle edge flags on the accepted level.
// Ports:
//   clk      system clock
//   reset_n  asynchronous active-low reset (idle bus level 1 is assumed)
//   pad_i    raw pad input
//   level_o  filtered level
//   rise_o   1 for the first cycle level_o is 1 after being 0
//   fall_o   1 for the first cycle level_o is 0 after being 1
// ---------------------------------------------------------------------------
module i2c_line_filter #(
  parameter int FILTER_LEN = 3
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pad_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [1:0]       sync_q;
  logic             level_q, level_d;
  logic [CNT_W-1:0] stableCnt_q, stableCnt_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  // Synchroniser, accepted level, stability counter and edge flags.
  // Reset to the idle-high bus level so that reset release never fakes an edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q      <= 2'b11;
      level_q     <= 1'b1;
      stableCnt_q <= '0;
      rise_q      <= 1'b0;
      fall_q      <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], pad_i};
      level_q     <= level_d;
      stableCnt_q <= stableCnt_d;
      rise_q      <= rise_d;
      fall_q      <= fall_d;
    end
  end

  // Count how long the synchronised input has disagreed with the accepted
  // level; any return to the accepted level restarts the count, so a pulse
  // shorter than FILTER_LEN cycles is swallowed.
  always_comb begin
    level_d     = level_q;
    stableCnt_d = '0;
    rise_d      = 1'b0;
    fall_d      = 1'b0;
    if (sync_q[1] != level_q) begin
      if (stableCnt_q == CNT_W'(FILTER_LEN - 1)) begin
        level_d = sync_q[1];
        rise_d  = sync_q[1];
        fall_d  = ~sync_q[1];
      end else begin
        stableCnt_d = stableCnt_q + CNT_W'(1);
      end
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/i2c_rtc_responder.sv
// ---------------------------------------------------------------------------
// i2c_rtc_responder
// I2C target emulating a DS1307-style RTC register bank. Supports pointer
// write, data writes with auto-increment, and current/random-address reads
// with auto-increment. The register image is exported in parallel and can be
// preloaded in one cycle.
// Ports:
//   clk        system clock, the only clock
//   reset_n    asynchronous active-low reset
//   bus        I2C pads (slave modport: scl_i, sda_i in; sda_oe out)
//   regs_o     register image, reg n at regs_o[8n+7:8n]
//   load       one-cycle strobe copying load_data into all registers
//   load_data  preload image, same layout as regs_o
//   wr_strobe  one-cycle pulse when the master commits a data byte
//   wr_addr    register index of that committed byte
//   busy       1 from an addressed START until STOP / read NACK / mismatch
// ---------------------------------------------------------------------------
module i2c_rtc_responder
  import i2c_rtc_responder_pkg::*;
#(
  parameter logic [6:0] I2C_ADDR   = DEFAULT_I2C_ADDR,
  parameter int         NREGS      = 8,
  parameter int         FILTER_LEN = 3,
  localparam int        PTR_W      = (NREGS > 1) ? $clog2(NREGS) : 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  i2c_rtc_responder_if.slave   bus,
  output logic [8*NREGS-1:0]   regs_o,
  input  logic                 load,
  input  logic [8*NREGS-1:0]   load_data,
  output logic                 wr_strobe,
  output logic [PTR_W-1:0]     wr_addr,
  output logic                 busy
);

  logic sclLevel, sclRise, sclFall;
  logic sdaLevel, sdaRise, sdaFall;
  logic startDet, stopDet;

  rtcState_t        state_q, state_d;
  logic [3:0]       bitCnt_q, bitCnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [PTR_W-1:0] pointer_q, pointer_d;
  logic             sdaOe_q, sdaOe_d;
  logic             busy_q, busy_d;
  logic             wrStrobe_q, wrStrobe_d;
  logic [PTR_W-1:0] wrAddr_q, wrAddr_d;
  logic [7:0]       regs_q [NREGS];
  logic             commit;
  logic [7:0]       rxByte;
  logic [PTR_W-1:0] pointerNext;

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sclFilter (
    .clk     (clk),
    .reset_n (reset_n),
    .pad_i   (bus.scl_i),
    .level_o (sclLevel),
    .rise_o  (sclRise),
    .fall_o  (sclFall)
  );

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sdaFilter (
    .clk     (clk),
    .reset_n (reset_n),
    .pad_i   (bus.sda_i),
    .level_o (sdaLevel),
    .rise_o  (sdaRise),
    .fall_o  (sdaFall)
  );

  assign startDet    = sdaFall & sclLevel;
  assign stopDet     = sdaRise & sclLevel;
  assign rxByte      = {shift_q[6:0], sdaLevel};
  assign pointerNext = (pointer_q == PTR_W'(NREGS - 1)) ? '0 : pointer_q + PTR_W'(1);

  // Protocol state, bit counter, shift register, pointer and pad drive.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      bitCnt_q   <= '0;
      shift_q    <= '0;
      pointer_q  <= '0;
      sdaOe_q    <= 1'b0;
      busy_q     <= 1'b0;
      wrStrobe_q <= 1'b0;
      wrAddr_q   <= '0;
    end else begin
      state_q    <= state_d;
      bitCnt_q   <= bitCnt_d;
      shift_q    <= shift_d;
      pointer_q  <= pointer_d;
      sdaOe_q    <= sdaOe_d;
      busy_q     <= busy_d;
      wrStrobe_q <= wrStrobe_d;
      wrAddr_q   <= wrAddr_d;
    end
  end

  // Next-state logic. STOP and START override every state. Bits are taken on
  // SCL rising edges; the SDA drive only moves on SCL falling edges. In the
  // ACK states the current drive tells the first falling edge (start ACK)
  // from the second (end ACK). A read byte is copied into the shift register
  // when it is launched, so a later preload does not change it mid-byte.
  always_comb begin
    state_d    = state_q;
    bitCnt_d   = bitCnt_q;
    shift_d    = shift_q;
    pointer_d  = pointer_q;
    sdaOe_d    = sdaOe_q;
    busy_d     = busy_q;
    wrStrobe_d = 1'b0;
    wrAddr_d   = wrAddr_q;
    commit     = 1'b0;

    if (stopDet) begin
      state_d  = ST_IDLE;
      sdaOe_d  = 1'b0;
      busy_d   = 1'b0;
      bitCnt_d = '0;
    end else if (startDet) begin
      state_d  = ST_ADDR;
      sdaOe_d  = 1'b0;
      bitCnt_d = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
        end

        ST_ADDR: begin
          if (sclRise) begin
            shift_d  = rxByte;
            bitCnt_d = bitCnt_q + 4'd1;
            if (bitCnt_q == 4'd7) begin
              bitCnt_d = '0;
              if (rxByte[7:1] == I2C_ADDR) begin
                state_d = ST_ADDR_ACK;
                busy_d  = 1'b1;
              end else begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
              end
            end
          end
        end

        ST_ADDR_ACK: begin
          if (sclFall) begin
            if (!sdaOe_q) begin
              sdaOe_d = 1'b1;
            end else if (shift_q[0]) begin
              state_d  = ST_RD_BYTE;
              shift_d  = regs_q[pointer_q];
              sdaOe_d  = ~regs_q[pointer_q][7];
              bitCnt_d = '0;
            end else begin
              state_d  = ST_WR_PTR;
              sdaOe_d  = 1'b0;
              bitCnt_d = '0;
            end
          end
        end

        ST_WR_PTR: begin
          if (sclRise) begin
            shift_d  = rxByte;
            bitCnt_d = bitCnt_q + 4'd1;
            if (bitCnt_q == 4'd7) begin
              bitCnt_d  = '0;
              pointer_d = PTR_W'(rxByte % 8'(NREGS));
              state_d   = ST_WR_ACK;
            end
          end
        end

        ST_WR_DATA: begin
          if (sclRise) begin
            shift_d  = rxByte;
            bitCnt_d = bitCnt_q + 4'd1;
            if (bitCnt_q == 4'd7) begin
              bitCnt_d   = '0;
              commit     = 1'b1;
              wrStrobe_d = 1'b1;
              wrAddr_d   = pointer_q;
              pointer_d  = pointerNext;
              state_d    = ST_WR_ACK;
            end
          end
        end

        ST_WR_ACK: begin
          if (sclFall) begin
            if (!sdaOe_q) begin
              sdaOe_d = 1'b1;
            end else begin
              sdaOe_d  = 1'b0;
              state_d  = ST_WR_DATA;
              bitCnt_d = '0;
            end
          end
        end

        ST_RD_BYTE: begin
          if (sclRise) begin
            bitCnt_d = bitCnt_q + 4'd1;
          end else if (sclFall) begin
            if (bitCnt_q == 4'd8) begin
              sdaOe_d   = 1'b0;
              pointer_d = pointerNext;
              bitCnt_d  = '0;
              state_d   = ST_RD_ACK;
            end else begin
              shift_d = {shift_q[6:0], 1'b0};
              sdaOe_d = ~shift_q[6];
            end
          end
        end

        ST_RD_ACK: begin
          if (sclRise) begin
            if (sdaLevel) begin
              state_d = ST_IDLE;
              busy_d  = 1'b0;
            end
          end else if (sclFall) begin
            state_d  = ST_RD_BYTE;
            shift_d  = regs_q[pointer_q];
            sdaOe_d  = ~regs_q[pointer_q][7];
            bitCnt_d = '0;
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Register file: an I2C commit wins for its own register, every other
  // register follows a simultaneous preload.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (commit && (pointer_q == PTR_W'(i))) begin
          regs_q[i] <= rxByte;
        end else if (load) begin
          regs_q[i] <= load_data[8*i +: 8];
        end
      end
    end
  end

  for (genvar g = 0; g < NREGS; g++) begin : gRegsOut
    assign regs_o[8*g +: 8] = regs_q[g];
  end

  // The pad is released during reset and on the STOP cycle itself, without
  // waiting for a clock edge.
  assign bus.sda_oe = sdaOe_q & reset_n & ~stopDet;
  assign wr_strobe  = wrStrobe_q;
  assign wr_addr    = wrAddr_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_i2c_rtc_responder.sv
// ---------------------------------------------------------------------------
// tb_i2c_rtc_responder
// Bit-banged I2C master driving the RTC responder through its pad interface.
// Expected ACK bits, read bytes and register commits are queued when the
// stimulus is issued; independent monitor processes pop and compare them when
// the responder presents the matching output.
// ---------------------------------------------------------------------------
module tb_i2c_rtc_responder;
  import i2c_rtc_responder_pkg::*;

  localparam int Q = 10;

  typedef struct {
    logic [2:0] addr;
    logic [7:0] data;
  } wrExp_t;

  logic        clk;
  logic        reset_n;
  logic        sclM;
  logic        sdaM;
  logic [63:0] regs_o;
  logic        load;
  logic [63:0] load_data;
  logic        wr_strobe;
  logic [2:0]  wr_addr;
  logic        busy;

  int nChecks;
  int nFails;

  wrExp_t     expWrQ[$];
  logic       expAckQ[$];
  logic [7:0] expRdQ[$];

  logic       ackBit;
  logic [7:0] rdByte;
  logic       sawOe;
  event       ackEv;
  event       rdEv;

  i2c_rtc_responder_if bus ();

  assign bus.scl_i = sclM;
  assign bus.sda_i = sdaM & ~bus.sda_oe;

  i2c_rtc_responder dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .regs_o    (regs_o),
    .load      (load),
    .load_data (load_data),
    .wr_strobe (wr_strobe),
    .wr_addr   (wr_addr),
    .busy      (busy)
  );

  // 50 MHz system clock.
  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  // Single comparison point: every check goes through here.
  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Commit monitor: each wr_strobe cycle must match the next queued write.
  always @(negedge clk) begin
    if (reset_n && wr_strobe) begin
      if (expWrQ.size() == 0) begin
        checkOutput("wrStrobeUnexpected", 64'(wr_strobe), 64'd0);
      end else begin
        wrExp_t e;
        e = expWrQ.pop_front();
        checkOutput("wrAddr", 64'(wr_addr), 64'(e.addr));
        checkOutput("wrData", 64'(regs_o[8*e.addr +: 8]), 64'(e.data));
      end
    end
  end

  // ACK monitor: compares each sampled ninth bit with the queued expectation.
  always begin
    @(ackEv);
    if (expAckQ.size() != 0) begin
      logic e;
      e = expAckQ.pop_front();
      checkOutput("ackBit", 64'(ackBit), 64'(e));
    end
  end

  // Read-data monitor.
  always begin
    @(rdEv);
    if (expRdQ.size() != 0) begin
      logic [7:0] e;
      e = expRdQ.pop_front();
      checkOutput("readByte", 64'(rdByte), 64'(e));
    end
  end

  // Records any SDA pull-down for the address-mismatch case.
  always @(posedge clk) begin
    if (bus.sda_oe) sawOe <= 1'b1;
  end

  // Bound on total run time.
  initial begin
    repeat (60000) @(posedge clk);
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    nFails++;
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic waitClk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic doLoad(input logic [63:0] img);
    load_data = img;
    load      = 1'b1;
    waitClk(1);
    load      = 1'b0;
    waitClk(1);
  endtask

  task automatic i2cStart();
    sdaM = 1'b1; waitClk(Q);
    sclM = 1'b1; waitClk(Q);
    sdaM = 1'b0; waitClk(Q);
    sclM = 1'b0; waitClk(Q);
  endtask

  task automatic i2cStop();
    sdaM = 1'b0; waitClk(Q);
    sclM = 1'b1; waitClk(Q);
    sdaM = 1'b1; waitClk(Q);
  endtask

  task automatic writeBit(input logic b);
    sdaM = b;    waitClk(Q);
    sclM = 1'b1; waitClk(2*Q);
    sclM = 1'b0; waitClk(Q);
  endtask

  task automatic readBit(output logic b);
    sdaM = 1'b1; waitClk(Q);
    sclM = 1'b1; waitClk(Q);
    b = bus.sda_i;
    waitClk(Q);
    sclM = 1'b0; waitClk(Q);
  endtask

  task automatic writeByte(input logic [7:0] data, input logic expAck);
    logic a;
    expAckQ.push_back(expAck);
    for (int i = 7; i >= 0; i--) writeBit(data[i]);
    readBit(a);
    ackBit = a;
    -> ackEv;
  endtask

  task automatic readByte(input logic [7:0] expVal, input logic nack);
    logic [7:0] v;
    logic       b;
    expRdQ.push_back(expVal);
    v = '0;
    for (int i = 7; i >= 0; i--) begin
      readBit(b);
      v[i] = b;
    end
    rdByte = v;
    -> rdEv;
    writeBit(nack);
  endtask

  task automatic pushWr(input logic [2:0] a, input logic [7:0] d);
    wrExp_t e;
    e.addr = a;
    e.data = d;
    expWrQ.push_back(e);
  endtask

  // Directed sequence of transactions.
  task automatic applyStimulus();
    // Reset values.
    waitClk(3);
    checkOutput("rstSdaOe", 64'(bus.sda_oe), 64'd0);
    checkOutput("rstRegs", regs_o, 64'd0);
    checkOutput("rstWrStrobe", 64'(wr_strobe), 64'd0);
    checkOutput("rstWrAddr", 64'(wr_addr), 64'd0);
    checkOutput("rstBusy", 64'(busy), 64'd0);
    reset_n = 1'b1;
    waitClk(5);

    // Write one register, then current-address read from the advanced pointer.
    doLoad(64'h7766554433221100);
    checkOutput("loadImage1", regs_o, 64'h7766554433221100);
    i2cStart();
    writeByte(8'hD0, 1'b0);
    checkOutput("busyAddressed", 64'(busy), 64'd1);
    writeByte(8'h02, 1'b0);
    pushWr(3'(REG_HOUR), 8'h12);
    writeByte(8'h12, 1'b0);
    i2cStop();
    checkOutput("busyAfterStop", 64'(busy), 64'd0);
    checkOutput("regsWrite", regs_o, 64'h7766554433121100);
    i2cStart();
    writeByte(8'hD1, 1'b0);
    readByte(8'h33, 1'b1);
    i2cStop();

    // Random read after preload: set pointer, repeated START, three bytes.
    doLoad(64'h0706050403305945);
    checkOutput("loadImage2", regs_o, 64'h0706050403305945);
    i2cStart();
    writeByte(8'hD0, 1'b0);
    writeByte(8'h00, 1'b0);
    i2cStart();
    writeByte(8'hD1, 1'b0);
    readByte(8'h45, 1'b0);
    readByte(8'h59, 1'b0);
    readByte(8'h30, 1'b1);
    checkOutput("busyAfterNack", 64'(busy), 64'd0);
    i2cStop();

    // Address mismatch: no pull-down at all, not busy, registers untouched.
    sawOe = 1'b0;
    i2cStart();
    writeByte(8'hA0, 1'b1);
    checkOutput("busyMismatch", 64'(busy), 64'd0);
    i2cStop();
    checkOutput("sdaNeverDriven", 64'(sawOe), 64'd0);
    checkOutput("regsMismatch", regs_o, 64'h0706050403305945);

    // Pointer wrap from the last register back to register 0.
    i2cStart();
    writeByte(8'hD0, 1'b0);
    writeByte(8'h07, 1'b0);
    pushWr(3'(REG_CTRL), 8'hAA);
    writeByte(8'hAA, 1'b0);
    pushWr(3'(REG_SEC), 8'hBB);
    writeByte(8'hBB, 1'b0);
    i2cStop();
    checkOutput("regsWrap", regs_o, 64'hAA060504033059BB);

    // Abort a data byte after four bits.
    i2cStart();
    writeByte(8'hD0, 1'b0);
    writeByte(8'h03, 1'b0);
    writeBit(1'b1);
    writeBit(1'b0);
    writeBit(1'b1);
    writeBit(1'b0);
    i2cStop();
    checkOutput("regsAbort", regs_o, 64'hAA060504033059BB);
    checkOutput("busyAbort", 64'(busy), 64'd0);
    checkOutput("sdaOeAbort", 64'(bus.sda_oe), 64'd0);

    // One-cycle SCL glitch before the pointer byte must not count as a bit.
    i2cStart();
    writeByte(8'hD0, 1'b0);
    sdaM = 1'b1; waitClk(Q);
    sclM = 1'b1; waitClk(1);
    sclM = 1'b0; waitClk(Q);
    writeByte(8'h05, 1'b0);
    pushWr(3'(REG_MONTH), 8'h5A);
    writeByte(8'h5A, 1'b0);
    i2cStop();
    checkOutput("regsGlitch", regs_o, 64'hAA065A04033059BB);

    // Reset while the responder is driving the address ACK.
    i2cStart();
    for (int i = 7; i >= 0; i--) writeBit(1'(8'hD0 >> i));
    checkOutput("ackDriving", 64'(bus.sda_oe), 64'd1);
    checkOutput("busyBeforeReset", 64'(busy), 64'd1);
    reset_n = 1'b0;
    #1;
    checkOutput("sdaOeInReset", 64'(bus.sda_oe), 64'd0);
    checkOutput("busyInReset", 64'(busy), 64'd0);
    checkOutput("regsInReset", regs_o, 64'd0);
    waitClk(3);
    reset_n = 1'b1;
    waitClk(3);
    i2cStop();
    checkOutput("sdaOeAfterReset", 64'(bus.sda_oe), 64'd0);
  endtask

  initial begin
    nChecks   = 0;
    nFails    = 0;
    reset_n   = 1'b0;
    sclM      = 1'b1;
    sdaM      = 1'b1;
    load      = 1'b0;
    load_data = '0;
    ackBit    = 1'b1;
    rdByte    = '0;
    sawOe     = 1'b0;
    applyStimulus();
    waitClk(5);
    checkOutput("wrQueueDrained", 64'(expWrQ.size()), 64'd0);
    checkOutput("ackQueueDrained", 64'(expAckQ.size()), 64'd0);
    checkOutput("rdQueueDrained", 64'(expRdQ.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
